// File: rtl/wb_regfile_sequencer_if.sv
// Writeback, reservation and architectural-state bundle for wb_regfile_sequencer.
// The master side (writeback/issue) drives requests; the slave side (sequencer) returns state.
interface wb_regfile_sequencer_if #(
    parameter int NUM_REGS = 16,
    parameter int DATA_W   = 64
);
    logic                               wbValidIn;
    logic                               wbReadyOut;
    logic [3:0]                         destRegIn;
    logic [DATA_W-1:0]                  aluResultIn;
    logic                               destRegSpecialValidIn;
    logic [3:0]                         destRegSpecialIn;
    logic [DATA_W-1:0]                  aluResultSpecialIn;

    logic                               reserveValidIn;
    logic [3:0]                         sourceReg1In;
    logic [3:0]                         sourceReg2In;
    logic                               sourceReg1ValidIn;
    logic                               sourceReg2ValidIn;
    logic                               reserveDestValidIn;
    logic [3:0]                         reserveDestIn;
    logic                               reserveGrantOut;

    logic [NUM_REGS-1:0][DATA_W-1:0]    regFileOut;
    logic [NUM_REGS-1:0]                regInUseBitMapOut;
    logic [31:0]                        writeCountOut;

    modport master (
        output wbValidIn, destRegIn, aluResultIn,
        output destRegSpecialValidIn, destRegSpecialIn, aluResultSpecialIn,
        output reserveValidIn, sourceReg1In, sourceReg2In,
        output sourceReg1ValidIn, sourceReg2ValidIn, reserveDestValidIn, reserveDestIn,
        input  wbReadyOut, reserveGrantOut, regFileOut, regInUseBitMapOut, writeCountOut
    );

    modport slave (
        input  wbValidIn, destRegIn, aluResultIn,
        input  destRegSpecialValidIn, destRegSpecialIn, aluResultSpecialIn,
        input  reserveValidIn, sourceReg1In, sourceReg2In,
        input  sourceReg1ValidIn, sourceReg2ValidIn, reserveDestValidIn, reserveDestIn,
        output wbReadyOut, reserveGrantOut, regFileOut, regInUseBitMapOut, writeCountOut
    );
endinterface

// File: rtl/wb_regfile_sequencer.sv
// Register file + in-use bitmap owner; serializes writebacks onto one write port.
// Optional macro RELEASE_BYPASS_EN: a register being released this edge counts as free for grants.
module wb_regfile_sequencer #(
    parameter int NUM_REGS = 16,
    parameter int DATA_W   = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    wb_regfile_sequencer_if.slave  bus
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_SECOND = 1'b1
    } state_t;

    localparam logic [NUM_REGS-1:0] ONE_HOT_BASE = {{(NUM_REGS-1){1'b0}}, 1'b1};

    state_t                            r_state;
    state_t                            w_state_nxt;

    logic [NUM_REGS-1:0][DATA_W-1:0]   r_regfile;
    logic [NUM_REGS-1:0]               r_inuse;
    logic [31:0]                       r_wr_count;
    logic [3:0]                        r_spec_reg;
    logic [DATA_W-1:0]                 r_spec_data;

    logic                              w_wb_ready;
    logic                              w_accept;
    logic                              w_latch_special;
    logic                              w_wr_en;
    logic [3:0]                        w_wr_idx;
    logic [DATA_W-1:0]                 w_wr_data;
    logic [NUM_REGS-1:0]               w_clr_mask;
    logic [NUM_REGS-1:0]               w_set_mask;
    logic [NUM_REGS-1:0]               w_busy_view;
    logic                              w_src1_hazard;
    logic                              w_src2_hazard;
    logic                              w_dest_hazard;
    logic                              w_grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The single write port carries the primary result on acceptance, or the
    // latched special result during SECOND; the FSM selects which.
    always_comb begin
        w_state_nxt     = r_state;
        w_wb_ready      = 1'b0;
        w_accept        = 1'b0;
        w_latch_special = 1'b0;
        w_wr_en         = 1'b0;
        w_wr_idx        = '0;
        w_wr_data       = '0;
        unique case (r_state)
            S_IDLE: begin
                w_wb_ready = 1'b1;
                w_accept   = bus.wbValidIn;
                if (w_accept) begin
                    w_wr_en   = 1'b1;
                    w_wr_idx  = bus.destRegIn;
                    w_wr_data = bus.aluResultIn;
                    if (bus.destRegSpecialValidIn) begin
                        w_latch_special = 1'b1;
                        w_state_nxt     = S_SECOND;
                    end
                end
            end
            S_SECOND: begin
                w_wr_en     = 1'b1;
                w_wr_idx    = r_spec_reg;
                w_wr_data   = r_spec_data;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_clr_mask = w_wr_en ? (ONE_HOT_BASE << w_wr_idx) : '0;

`ifdef RELEASE_BYPASS_EN
    assign w_busy_view = r_inuse & ~w_clr_mask;
`else
    assign w_busy_view = r_inuse;
`endif

    assign w_src1_hazard = bus.sourceReg1ValidIn  && w_busy_view[bus.sourceReg1In];
    assign w_src2_hazard = bus.sourceReg2ValidIn  && w_busy_view[bus.sourceReg2In];
    assign w_dest_hazard = bus.reserveDestValidIn && w_busy_view[bus.reserveDestIn];
    assign w_grant       = bus.reserveValidIn && !w_src1_hazard && !w_src2_hazard && !w_dest_hazard;

    assign w_set_mask = (w_grant && bus.reserveDestValidIn) ? (ONE_HOT_BASE << bus.reserveDestIn) : '0;

    // Set is applied after clear so a same-edge reservation keeps the bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_inuse    <= '0;
            r_wr_count <= '0;
        end else begin
            r_inuse <= (r_inuse & ~w_clr_mask) | w_set_mask;
            if (w_wr_en) begin
                r_wr_count <= r_wr_count + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_regfile <= '0;
        end else if (w_wr_en) begin
            r_regfile[w_wr_idx] <= w_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (w_latch_special) begin
            r_spec_reg  <= bus.destRegSpecialIn;
            r_spec_data <= bus.aluResultSpecialIn;
        end
    end

    assign bus.wbReadyOut        = w_wb_ready;
    assign bus.reserveGrantOut   = w_grant;
    assign bus.regFileOut        = r_regfile;
    assign bus.regInUseBitMapOut = r_inuse;
    assign bus.writeCountOut     = r_wr_count;

endmodule
